// File: rtl/keypad_pkg.sv
// Shared types and constants for the 3x4 matrix keypad scanner.
// Key code bit index is row*3 + col.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    localparam int NUM_COLS = 3;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    localparam int KEY_1    = 0;
    localparam int KEY_2    = 1;
    localparam int KEY_3    = 2;
    localparam int KEY_4    = 3;
    localparam int KEY_5    = 4;
    localparam int KEY_6    = 5;
    localparam int KEY_7    = 6;
    localparam int KEY_8    = 7;
    localparam int KEY_9    = 8;
    localparam int KEY_STAR = 9;
    localparam int KEY_0    = 10;
    localparam int KEY_HASH = 11;

    // True when exactly one key bit is set.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Resets to zero so no key is seen while leaving reset.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two register stages to settle metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// Column-scanning keypad reader with frame-level debounce.
// Emits one valid strobe with a one-hot key code per accepted press.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    output logic [NUM_KEYS-1:0] Scan_data,
    output logic                valid,
    output logic                key_held
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    logic [NUM_ROWS-1:0] row_s;
    logic [SW-1:0]       slot;
    logic [1:0]          col_idx;
    logic [NUM_KEYS-1:0] frame;
    logic [NUM_KEYS-1:0] sample;
    logic [NUM_KEYS-1:0] cand;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_inc;
    logic                at_limit;
    logic                slot_last;
    logic                frame_end;
    state_t              state;

    sync_2ff #(
        .W (NUM_ROWS)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_row),
        .q   (row_s)
    );

    assign slot_last = (slot == SW'(SCAN_DIV - 1));
    assign frame_end = slot_last && (col_idx == 2'd2);
    assign cnt_inc   = cnt + CW'(1);
    assign at_limit  = (cnt_inc == CW'(DEBOUNCE_FRAMES));

    // Frame contents with the current column's rows merged in.
    always_comb begin
        sample = frame;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_s[r]) begin
                sample[r*NUM_COLS + int'(col_idx)] = 1'b1;
            end
        end
    end

    // Slot timing, column rotation and frame accumulation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot    <= '0;
            col_idx <= '0;
            key_col <= 3'b001;
            frame   <= '0;
        end else if (slot_last) begin
            slot    <= '0;
            frame   <= frame_end ? '0 : sample;
            col_idx <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
            key_col <= {key_col[1:0], key_col[2]};
        end else begin
            slot <= slot + SW'(1);
        end
    end

    // Debounce FSM, stepped once per completed frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            valid     <= 1'b0;
            Scan_data <= '0;
            key_held  <= 1'b0;
        end else begin
            valid     <= 1'b0;
            Scan_data <= '0;
            if (frame_end) begin
                unique case (state)
                    IDLE: begin
                        if (is_onehot(sample)) begin
                            cand <= sample;
                            cnt  <= CW'(1);
                            if (DEBOUNCE_FRAMES == 1) begin
                                valid     <= 1'b1;
                                Scan_data <= sample;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (sample == cand) begin
                            cnt <= cnt_inc;
                            if (at_limit) begin
                                valid     <= 1'b1;
                                Scan_data <= cand;
                                key_held  <= 1'b1;
                                state     <= HELD;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        if (sample == '0) begin
                            cnt <= CW'(1);
                            if (DEBOUNCE_FRAMES == 1) begin
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (sample == '0) begin
                            cnt <= cnt_inc;
                            if (at_limit) begin
                                key_held <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a modelled 3x4 key matrix.
// Inputs change on negedges aligned to 12-clock frame boundaries.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] Scan_data;
    logic        valid;
    logic        key_held;

    logic [11:0] pressed = '0;
    int          errs    = 0;
    int          checks  = 0;
    int          pulses  = 0;
    int          stray   = 0;
    logic [11:0] last_code = '0;

    always #5 clk = ~clk;

    // Matrix model: a row is high when a pressed key sits in a driven column.
    always_comb begin
        key_row = '0;
        for (int r = 0; r < 4; r++) begin
            key_row[r] = |(pressed[r*3 +: 3] & key_col);
        end
    end

    keypad_scan #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .Scan_data (Scan_data),
        .valid     (valid),
        .key_held  (key_held)
    );

    // Pulse monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && valid) begin
            pulses    <= pulses + 1;
            last_code <= Scan_data;
        end
        if (rst && !valid && Scan_data != '0) begin
            stray <= stray + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (12 * n) @(negedge clk);
    endtask

    initial begin
        int p0;

        // Reset state and column rotation.
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(key_col), 32'h1);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_data", 32'(Scan_data), 32'h0);
        chk("rst_held", 32'(key_held), 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rot_col1", 32'(key_col), 32'h2);
        repeat (4) @(negedge clk);
        chk("rot_col2", 32'(key_col), 32'h4);
        repeat (4) @(negedge clk);
        chk("rot_col0", 32'(key_col), 32'h1);
        frames(1);

        // Key '5' for 6 frames then release.
        p0 = pulses;
        pressed = 12'h010;
        frames(2);
        chk("k5_early", 32'(valid), 32'h0);
        chk("k5_noheld", 32'(key_held), 32'h0);
        frames(1);
        chk("k5_valid", 32'(valid), 32'h1);
        chk("k5_data", 32'(Scan_data), 32'h010);
        chk("k5_held", 32'(key_held), 32'h1);
        @(negedge clk);
        chk("k5_drop", 32'(valid), 32'h0);
        chk("k5_dropd", 32'(Scan_data), 32'h0);
        repeat (12 * 3 - 1) @(negedge clk);
        pressed = '0;
        frames(2);
        chk("k5_rel2", 32'(key_held), 32'h1);
        frames(1);
        chk("k5_rel3", 32'(key_held), 32'h0);
        chk("k5_pulses", 32'(pulses - p0), 32'h1);
        chk("k5_code", 32'(last_code), 32'h010);
        frames(1);

        // '#' too short, then long enough.
        p0 = pulses;
        pressed = 12'h800;
        frames(2);
        pressed = '0;
        frames(2);
        chk("hs_short", 32'(pulses - p0), 32'h0);
        pressed = 12'h800;
        frames(4);
        chk("hs_held", 32'(key_held), 32'h1);
        pressed = '0;
        frames(3);
        chk("hs_pulses", 32'(pulses - p0), 32'h1);
        chk("hs_code", 32'(last_code), 32'h800);
        chk("hs_idle", 32'(key_held), 32'h0);
        frames(1);

        // '1' and '*' together: never accepted.
        p0 = pulses;
        pressed = 12'h201;
        frames(5);
        chk("mk_pulses", 32'(pulses - p0), 32'h0);
        chk("mk_held", 32'(key_held), 32'h0);
        pressed = '0;
        frames(1);

        // '0' with a one-frame release glitch.
        p0 = pulses;
        pressed = 12'h400;
        frames(10);
        pressed = '0;
        frames(1);
        chk("g0_mid", 32'(key_held), 32'h1);
        pressed = 12'h400;
        frames(9);
        chk("g0_held", 32'(key_held), 32'h1);
        pressed = '0;
        frames(3);
        chk("g0_pulses", 32'(pulses - p0), 32'h1);
        chk("g0_code", 32'(last_code), 32'h400);
        chk("g0_idle", 32'(key_held), 32'h0);
        frames(1);

        // '*' debounce aborted by reset, key kept down.
        p0 = pulses;
        pressed = 12'h200;
        frames(2);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("ab_pulses", 32'(pulses - p0), 32'h0);
        chk("ab_col", 32'(key_col), 32'h1);
        chk("ab_valid", 32'(valid), 32'h0);
        rst = 1'b1;
        frames(2);
        chk("ab_early", 32'(valid), 32'h0);
        frames(1);
        chk("ab_valid2", 32'(valid), 32'h1);
        chk("ab_data", 32'(Scan_data), 32'h200);
        @(negedge clk);
        chk("ab_pulses2", 32'(pulses - p0), 32'h1);
        pressed = '0;
        frames(4);

        chk("stray_data", 32'(stray), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 3-column x 4-row matrix keypad, debounces it and reports each new key press as a one-hot 12-bit code with a one-cycle valid strobe.
- Drives the Display block's valid/Scan_data inputs; it is the producer end of that interface.
- Sits between the board keypad pins and Display, in the same clock and reset domain.

Parameters:
- SCAN_DIV, 4, clocks per column slot; minimum 3 (synchronizer latency); board build uses 1000.
- DEBOUNCE_FRAMES, 3, consecutive identical frames required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- key_row  input  4  keypad row lines; asynchronous; active-high when a key in the driven column is pressed.
- key_col  output  3  one-hot column drive, active-high.
- Scan_data  output  12  one-hot key code; non-zero only in the cycle valid=1, else 12'b0.
- valid  output  1  one-cycle strobe, one per accepted press.
- key_held  output  1  high while in HELD or RELEASE state.

Behaviour:
- Reset (rst=0, asynchronous):
  - key_col=3'b001, Scan_data=0, valid=0, key_held=0.
  - state=IDLE; slot counter, column index, frame register, candidate and debounce count all cleared.
- Key code: bit = row*3 + col.
  - row0 = keys 1,2,3; row1 = 4,5,6; row2 = 7,8,9; row3 = *,0,#.
  - So bit0='1', bit4='5', bit9='*', bit10='0', bit11='#'.
- Scanning:
  - key_row passes through a 2-FF synchronizer.
  - The slot counter runs 0..SCAN_DIV-1. On its last cycle, the synchronized rows are written into frame bits [row*3+col] for the current column, and the column then advances 0->1->2->0.
  - key_col changes on the cycle after the sample.
  - A frame is complete at the end of the col2 slot: 3*SCAN_DIV clocks per frame.
  - frame_code is evaluated at frame end; the frame register is then cleared for the next frame.
- FSM, evaluated only at frame end. "One-hot" means exactly one bit set.
  - IDLE:
    - frame_code one-hot: candidate=frame_code, cnt=1.
    - If DEBOUNCE_FRAMES==1, emit a press (below) and go to HELD; otherwise go to DEBOUNCE.
    - frame_code zero or multi-bit: stay in IDLE.
  - DEBOUNCE:
    - frame_code==candidate: cnt++. When cnt reaches DEBOUNCE_FRAMES, emit a press and go to HELD.
    - Any mismatch: go to IDLE, cnt=0, no output.
  - HELD:
    - frame_code==0: cnt=1; go to RELEASE, or straight to IDLE if DEBOUNCE_FRAMES==1.
    - Any non-zero frame, including extra keys: stay in HELD. No repeat strobe.
  - RELEASE:
    - frame_code==0: cnt++. When cnt reaches DEBOUNCE_FRAMES, go to IDLE.
    - Non-zero frame: return to HELD, no new strobe.
- Emitting a press: in the cycle after the frame-end edge, valid=1 and Scan_data=candidate. Both return to 0 on the next cycle.
- Latency: valid rises 1 clock after the end of the DEBOUNCE_FRAMES-th consecutive matching frame.
- Simultaneous keys:
  - Multi-bit frames never start or advance a press.
  - A second key added while in HELD is ignored until a full release.
- Reset mid-operation: an aborted debounce never produces valid; scanning restarts at col0.
- Counter widths: slot counter $clog2(SCAN_DIV); debounce count $clog2(DEBOUNCE_FRAMES+1).

Decomposition:
- Package keypad_pkg contains:
  - state enum IDLE/DEBOUNCE/HELD/RELEASE;
  - key-index localparams (KEY_1..KEY_9, KEY_STAR=9, KEY_0=10, KEY_HASH=11);
  - NUM_COLS=3, NUM_ROWS=4.
- Sub-module sync_2ff (width parameter) for key_row.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=12 clocks; bench models the keypad from key_col):
- Reset: hold rst=0, then release -> key_col=3'b001, valid=0, Scan_data=0; key_col rotates every 4 clocks.
- Press '5' (row1 high while col1 driven) for 6 frames, then release -> exactly one valid pulse with Scan_data=12'h010, about 3 frames after press; key_held=1 until 3 zero frames after release.
- Press '#' for 2 frames only -> no valid. Then press it for 4 frames -> one pulse, Scan_data=12'h800.
- Press '1' and '*' together for 5 frames -> no valid, state stays IDLE.
- Press '0' held for 20 frames with a 1-frame release glitch mid-hold -> single pulse 12'h400, no second pulse.
- Press '*' for 2 frames, assert rst=0 for 3 clocks, keep key pressed -> no pulse before reset; after reset, one pulse 12'h200 three frames later.
